// File: rtl/speed_tick_gen.sv
// speed_tick_gen: switch-selected rate tick generator.
// Two raw speed switches are synchronized and debounced, then select one of
// three power-of-two tick periods. A rate change waits for the current
// period's boundary, so the downstream counter never sees a short interval.
// Optional macro SPEED_TICK_PAUSE_EN: code 11 pauses the tick immediately;
// without it, code 11 selects the fast rate.
module speed_tick_gen #(
  parameter int DIV_FAST = 22,
  parameter int DIV_MED  = 23,
  parameter int DIV_SLOW = 24,
  parameter int DEB_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw2,
  input  logic       sw1,
  output logic       tick,
  output logic [1:0] rate,
  output logic       pending
);

  localparam int PW = DIV_SLOW;

  // Terminal prescaler values; the slow period sets the prescaler width.
  localparam logic [PW-1:0] MASK_SLOW = '1;
  localparam logic [PW-1:0] MASK_MED  = MASK_SLOW >> (DIV_SLOW - DIV_MED);
  localparam logic [PW-1:0] MASK_FAST = MASK_SLOW >> (DIV_SLOW - DIV_FAST);

  // Debounce counter has one extra bit so it can park after a commit.
  localparam logic [DEB_W:0] DEB_LAST = {1'b0, {DEB_W{1'b1}}};
  localparam logic [DEB_W:0] DEB_DONE = {1'b1, {DEB_W{1'b0}}};

  localparam logic [1:0] R_SLOW  = 2'd0;
  localparam logic [1:0] R_MED   = 2'd1;
  localparam logic [1:0] R_FAST  = 2'd2;
`ifdef SPEED_TICK_PAUSE_EN
  localparam logic [1:0] R_PAUSE = 2'd3;
`endif

  typedef enum logic {RUN, PEND} state_t;

  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      stab_q;
  logic [DEB_W:0]  deb_cnt_q, deb_cnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [PW-1:0]   mask_w;
  logic            tick_q;
  logic [1:0]      rate_q, tgt_q;
  state_t          state_q;
  logic            commit_w, wrap_w;
  logic [1:0]      new_rate_w;

  // Synchronizers, then track the last synchronized value and how long it held.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stab_q    <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= {sw2, sw1};
      sync2_q   <= sync1_q;
      stab_q    <= sync2_q;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Window restarts on any change; parks at DEB_DONE so a value commits once.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (sync2_q != stab_q)
      deb_cnt_d = '0;
    else if (deb_cnt_q != DEB_DONE)
      deb_cnt_d = deb_cnt_q + 1'b1;
  end

  // Commit fires on the single edge where the window completes.
  assign commit_w = (sync2_q == stab_q) && (deb_cnt_q == DEB_LAST);

  // Switch code equals the rate code except for 11.
  always_comb begin
    new_rate_w = stab_q;
`ifndef SPEED_TICK_PAUSE_EN
    if (stab_q == 2'b11) new_rate_w = R_FAST;
`endif
  end

  // Terminal count of the active rate; paused never reaches this path.
  always_comb begin
    case (rate_q)
      R_SLOW:  mask_w = MASK_SLOW;
      R_MED:   mask_w = MASK_MED;
      R_FAST:  mask_w = MASK_FAST;
      default: mask_w = MASK_FAST;
    endcase
  end

  assign wrap_w  = (presc_q == mask_w);
  assign presc_d = wrap_w ? '0 : presc_q + 1'b1;

  // Prescaler, tick and RUN/PEND rate FSM; rate switches only on a wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      rate_q  <= R_SLOW;
      tgt_q   <= R_SLOW;
      state_q <= RUN;
    end else
`ifdef SPEED_TICK_PAUSE_EN
    if (commit_w && (new_rate_w == R_PAUSE || rate_q == R_PAUSE)) begin
      // Entering or leaving pause acts at once and drops any pending change.
      presc_q <= '0;
      tick_q  <= 1'b0;
      rate_q  <= new_rate_w;
      state_q <= RUN;
    end else if (rate_q == R_PAUSE) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else
`endif
    begin
      presc_q <= presc_d;
      tick_q  <= wrap_w;
      if (commit_w) begin
        if (new_rate_w == rate_q)
          state_q <= RUN;
        else if (wrap_w && state_q == PEND) begin
          // Newest target wins when it lands on the boundary itself.
          rate_q  <= new_rate_w;
          state_q <= RUN;
        end else begin
          tgt_q   <= new_rate_w;
          state_q <= PEND;
        end
      end else if (wrap_w && state_q == PEND) begin
        rate_q  <= tgt_q;
        state_q <= RUN;
      end
    end
  end

  assign tick    = tick_q;
  assign rate    = rate_q;
  assign pending = (state_q == PEND);

endmodule

// File: tb/tb_speed_tick_gen.sv
// Bench for speed_tick_gen: behavioural model checked every cycle, directed
// scenarios with hand-computed timing, then randomized switch activity.
module tb_speed_tick_gen;
  localparam int DIV_FAST = 2;
  localparam int DIV_MED  = 3;
  localparam int DIV_SLOW = 4;
  localparam int DEB_W    = 2;
`ifdef SPEED_TICK_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw2 = 1'b0;
  logic       sw1 = 1'b0;
  logic       tick;
  logic [1:0] rate;
  logic       pending;

  speed_tick_gen #(
    .DIV_FAST(DIV_FAST), .DIV_MED(DIV_MED), .DIV_SLOW(DIV_SLOW), .DEB_W(DEB_W)
  ) dut (
    .clk(clk), .rst(rst), .sw2(sw2), .sw1(sw1),
    .tick(tick), .rate(rate), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gcyc = 0;
  int last_tick = -1;

  // Model state: sync delay line, age of synchronized value, period phase.
  logic [1:0] m_d1, m_d2, m_sprev, m_rate, m_tgt;
  int         m_age, m_el;
  bit         m_tick, m_pend;

  function automatic int period(input logic [1:0] r);
    case (r)
      2'd0:    return 1 << DIV_SLOW;
      2'd1:    return 1 << DIV_MED;
      default: return 1 << DIV_FAST;
    endcase
  endfunction

  function automatic logic [1:0] code_rate(input logic [1:0] c);
    if (c == 2'b11) return PAUSE ? 2'd3 : 2'd2;
    return c;
  endfunction

  task automatic model_edge(input bit r, input logic [1:0] x);
    logic [1:0] s, nr;
    bit commit, wrap, was;
    if (r) begin
      m_d1 = 0; m_d2 = 0; m_sprev = 0; m_age = 0; m_el = 0;
      m_tick = 0; m_rate = 0; m_tgt = 0; m_pend = 0;
      return;
    end
    s = m_d2; m_d2 = m_d1; m_d1 = x;
    commit = 0;
    if (s != m_sprev) begin
      m_sprev = s;
      m_age = 0;
    end else begin
      if (m_age < 100000) m_age++;
      commit = (m_age == (1 << DEB_W));
    end
    nr = code_rate(s);
    if (PAUSE && commit && (nr == 2'd3 || m_rate == 2'd3)) begin
      m_rate = nr; m_pend = 0; m_el = 0; m_tick = 0;
    end else if (PAUSE && m_rate == 2'd3) begin
      m_tick = 0; m_el = 0;
    end else begin
      wrap = (m_el == period(m_rate) - 1);
      m_tick = wrap;
      m_el = wrap ? 0 : m_el + 1;
      was = m_pend;
      if (commit) begin
        if (nr == m_rate) m_pend = 0;
        else begin m_pend = 1; m_tgt = nr; end
      end
      if (wrap && was && m_pend) begin
        m_rate = m_tgt;
        m_pend = 0;
      end
    end
  endtask

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock: drive at negedge, advance model, sample at the next negedge.
  task automatic step(input bit r, input logic [1:0] sw);
    rst = r; sw2 = sw[1]; sw1 = sw[0];
    model_edge(r, sw);
    @(posedge clk);
    @(negedge clk);
    gcyc++;
    cyc = r ? 0 : cyc + 1;
    checks++;
    if (tick !== m_tick || rate !== m_rate || pending !== m_pend) begin
      errors++;
      $display("FAIL model cyc=%0d tick %b exp %b rate %0d exp %0d pending %b exp %b",
               cyc, tick, m_tick, rate, m_rate, pending, m_pend);
    end
    if (tick === 1'b1) begin
      if (last_tick >= 0) begin
        checks++;
        if (gcyc - last_tick < (1 << DIV_FAST)) begin
          errors++;
          $display("FAIL min_interval got %0d expected >= %0d", gcyc - last_tick, 1 << DIV_FAST);
        end
      end
      last_tick = gcyc;
    end
  endtask

  initial begin
    int first_tick, pend_rise, rate_at, tick_at, cnt, p27, p28, t32, t48, rnz;
    logic [1:0] c;
    @(negedge clk);

    // A: reset state, slow ticks, then 00 -> 10 mid-period.
    step(1, 2'b00);
    check("reset_tick", tick, 0);
    check("reset_rate", rate, 0);
    check("reset_pending", pending, 0);
    first_tick = -1;
    while (cyc < 21) begin
      step(0, 2'b00);
      if (tick && first_tick < 0) first_tick = cyc;
    end
    check("a_first_tick", first_tick, 16);
    pend_rise = -1; rate_at = -1; tick_at = -1;
    while (cyc < 40) begin
      step(0, 2'b10);
      if (pending && pend_rise < 0) pend_rise = cyc;
      if (rate == 2 && rate_at < 0) rate_at = cyc;
      if (tick && cyc > 32 && tick_at < 0) tick_at = cyc;
    end
    check("a_commit_window", int'(pend_rise - 22 >= 4 && pend_rise - 22 <= 7), 1);
    check("a_rate_fast_at", rate_at, 32);
    check("a_fast_tick_at", tick_at, 36);

    // B: bouncing sw1 never commits; settled 01 switches at the slow boundary.
    step(1, 2'b00);
    while (cyc < 20) step(0, 2'b00);
    pend_rise = -1;
    for (int k = 0; k < 40; k++) begin
      c = ((k / 3) % 2 == 0) ? 2'b01 : 2'b00;
      step(0, c);
      if (pending && pend_rise < 0) pend_rise = cyc;
    end
    check("b_no_commit_bounce", pend_rise, -1);
    rate_at = -1; tick_at = -1;
    while (cyc < 100) begin
      step(0, 2'b01);
      if (pending && pend_rise < 0) pend_rise = cyc;
      if (rate == 1 && rate_at < 0) rate_at = cyc;
      if (tick && cyc > 80 && tick_at < 0) tick_at = cyc;
    end
    check("b_commit_window", int'(pend_rise - 61 >= 4 && pend_rise - 61 <= 7), 1);
    check("b_rate_med_at", rate_at, 80);
    check("b_med_tick_at", tick_at, 88);

    // C: commit 10, then 00 back before the boundary cancels cleanly.
    step(1, 2'b00);
    while (cyc < 16) step(0, 2'b00);
    while (cyc < 21) step(0, 2'b10);
    p27 = -1; p28 = -1; t32 = 0; t48 = 0; cnt = 0; rnz = 0;
    while (cyc < 50) begin
      step(0, 2'b00);
      if (cyc == 27) p27 = pending;
      if (cyc == 28) p28 = pending;
      if (rate != 0) rnz = 1;
      if (tick) begin
        cnt++;
        if (cyc == 32) t32 = 1;
        if (cyc == 48) t48 = 1;
      end
    end
    check("c_pending_27", p27, 1);
    check("c_pending_28", p28, 0);
    check("c_tick_32", t32, 1);
    check("c_tick_48", t48, 1);
    check("c_tick_count", cnt, 2);
    check("c_rate_stays_slow", rnz, 0);

    // D: reset while pending, on the edge a tick was due.
    step(1, 2'b00);
    while (cyc < 21) step(0, 2'b00);
    while (cyc < 31) step(0, 2'b10);
    check("d_pending_before_rst", pending, 1);
    step(1, 2'b00);
    check("d_rst_tick", tick, 0);
    check("d_rst_rate", rate, 0);
    check("d_rst_pending", pending, 0);
    first_tick = -1;
    while (cyc < 20) begin
      step(0, 2'b00);
      if (tick && first_tick < 0) first_tick = cyc;
    end
    check("d_first_tick", first_tick, 16);

    // E: code 11 at fast rate, then 01.
    step(1, 2'b00);
    while (cyc < 20) step(0, 2'b10);
    rate_at = -1; cnt = 0;
    while (cyc < 77) begin
      step(0, 2'b11);
      if (rate == 3 && rate_at < 0) rate_at = cyc;
      if (tick && cyc >= 28) cnt++;
    end
    if (PAUSE) begin
      check("e_pause_at", rate_at, 27);
      check("e_pause_ticks", cnt, 0);
    end else begin
      check("e_no_pause", rate_at, -1);
      check("e_rate_fast", rate, 2);
      check("e_fast_ticks", cnt, 13);
    end
    rate_at = -1; tick_at = -1;
    while (cyc < 110) begin
      step(0, 2'b01);
      if (rate == 1 && rate_at < 0) rate_at = cyc;
      if (tick && rate_at >= 0 && cyc > rate_at && tick_at < 0) tick_at = cyc;
    end
    if (PAUSE) begin
      check("e_resume_at", rate_at, 84);
      check("e_resume_tick", tick_at, 92);
    end else begin
      check("e_med_at", rate_at, 88);
      check("e_med_tick", tick_at, 96);
    end

    // F: randomized holds, bounces and occasional resets.
    step(1, 2'b00);
    for (int n = 0; n < 300; n++) begin
      int dur;
      c = 2'($urandom_range(0, 3));
      dur = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 60));
      if ($urandom_range(0, 29) == 0) step(1, c);
      for (int j = 0; j < dur; j++) step(0, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
